// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C command arbiter: sequencer states, command
// width and the well-known device addresses on the configuration bus.
package i2c_pkg;

    localparam int CMD_W = 24;

    localparam logic [7:0] DEV_AUDIO = 8'h34;
    localparam logic [7:0] DEV_VIDEO = 8'h40;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_END,
        RELEASE,
        CHECK,
        DONE
    } arbState_t;

endpackage

// File: rtl/i2c_cmd_arbiter_rr_arbiter.sv
// Combinational round-robin pick: search starts one past the last grant and
// wraps, so every requester is reached within NUM_REQ-1 transfers.
module rr_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   lastGrant,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   idx
);

    logic             found;
    logic [IDX_W-1:0] cand;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IDX_W'((int'(lastGrant) + k) % NUM_REQ);
            if (!found && req[cand]) begin
                found     = 1'b1;
                idx       = cand;
                gnt[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/i2c_cmd_arbiter.sv
// Serialises per-requester 24-bit register writes onto the shared I2C write
// engine, with NACK retry, GO-to-END timeout and per-requester done/error.
module i2c_cmd_arbiter
    import i2c_pkg::*;
#(
    parameter int NUM_REQ     = 3,
    parameter int MAX_RETRY   = 3,
    parameter int TIMEOUT_CYC = 2000000
) (
    input  logic                     iCLK,
    input  logic                     iRST_N,
    input  logic [NUM_REQ-1:0]       iREQ,
    input  logic [CMD_W*NUM_REQ-1:0] iCMD,
    output logic [NUM_REQ-1:0]       oGNT,
    output logic [NUM_REQ-1:0]       oDONE,
    output logic [NUM_REQ-1:0]       oERR,
    output logic                     oGO,
    output logic [CMD_W-1:0]         oDATA,
    input  logic                     iEND,
    input  logic                     iACK,
    output logic                     oBUSY
);

    localparam int          IDX_W     = $clog2(NUM_REQ);
    localparam logic [21:0] TO_LAST   = 22'(TIMEOUT_CYC - 1);
    localparam logic [21:0] TO_SAT    = 22'h3FFFFF;
    localparam logic [2:0]  RETRY_MAX = 3'(MAX_RETRY);

    arbState_t           state, stateNxt;
    logic [IDX_W-1:0]    idxReg, idxNxt;
    logic [IDX_W-1:0]    lastGrant, lastGrantNxt;
    logic [CMD_W-1:0]    cmdReg, cmdNxt;
    logic [2:0]          retryCnt, retryNxt;
    logic [21:0]         toCnt, toNxt, toInc;
    logic                errFlag, errFlagNxt;
    logic                ackReg, ackNxt;
    logic [NUM_REQ-1:0]  gntReg, gntNxt;
    logic [NUM_REQ-1:0]  doneReg, doneNxt;
    logic [NUM_REQ-1:0]  errReg, errNxt;
    logic                goReg, goNxt;
    logic [CMD_W-1:0]    dataReg, dataNxt;

    logic                endSync_p0, endSync_p1;
    logic                ackSync_p0, ackSync_p1;

    logic [NUM_REQ-1:0]  arbGnt;
    logic [IDX_W-1:0]    arbIdx;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) uArb (
        .req       (iREQ),
        .lastGrant (lastGrant),
        .gnt       (arbGnt),
        .idx       (arbIdx)
    );

    // Stage p0 -> p1: END/ACK cross in from the slow engine clock
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            endSync_p0 <= 1'b0;
            endSync_p1 <= 1'b0;
            ackSync_p0 <= 1'b0;
            ackSync_p1 <= 1'b0;
        end else begin
            endSync_p0 <= iEND;
            endSync_p1 <= endSync_p0;
            ackSync_p0 <= iACK;
            ackSync_p1 <= ackSync_p0;
        end
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state     <= IDLE;
            idxReg    <= '0;
            lastGrant <= IDX_W'(NUM_REQ - 1);
            cmdReg    <= '0;
            retryCnt  <= '0;
            toCnt     <= '0;
            errFlag   <= 1'b0;
            ackReg    <= 1'b0;
            gntReg    <= '0;
            doneReg   <= '0;
            errReg    <= '0;
            goReg     <= 1'b0;
            dataReg   <= '0;
        end else begin
            state     <= stateNxt;
            idxReg    <= idxNxt;
            lastGrant <= lastGrantNxt;
            cmdReg    <= cmdNxt;
            retryCnt  <= retryNxt;
            toCnt     <= toNxt;
            errFlag   <= errFlagNxt;
            ackReg    <= ackNxt;
            gntReg    <= gntNxt;
            doneReg   <= doneNxt;
            errReg    <= errNxt;
            goReg     <= goNxt;
            dataReg   <= dataNxt;
        end
    end

    assign toInc = (toCnt == TO_SAT) ? toCnt : toCnt + 22'd1;

    always_comb begin
        stateNxt     = state;
        idxNxt       = idxReg;
        lastGrantNxt = lastGrant;
        cmdNxt       = cmdReg;
        retryNxt     = retryCnt;
        toNxt        = toCnt;
        errFlagNxt   = errFlag;
        ackNxt       = ackReg;
        gntNxt       = gntReg;
        doneNxt      = '0;
        errNxt       = '0;
        goNxt        = goReg;
        dataNxt      = dataReg;

        case (state)
            IDLE: begin
                if (|iREQ) begin
                    idxNxt     = arbIdx;
                    gntNxt     = arbGnt;
                    cmdNxt     = iCMD[CMD_W*int'(arbIdx) +: CMD_W];
                    retryNxt   = '0;
                    errFlagNxt = 1'b0;
                    ackNxt     = 1'b0;
                    stateNxt   = ISSUE;
                end
            end
            ISSUE: begin
                goNxt    = 1'b1;
                dataNxt  = cmdReg;
                toNxt    = '0;
                stateNxt = WAIT_END;
            end
            WAIT_END: begin
                if (endSync_p1) begin
                    ackNxt   = ackSync_p1;
                    goNxt    = 1'b0;
                    toNxt    = '0;
                    stateNxt = RELEASE;
                end else if (toCnt == TO_LAST) begin
                    errFlagNxt = 1'b1;
                    goNxt      = 1'b0;
                    toNxt      = '0;
                    stateNxt   = RELEASE;
                end else begin
                    toNxt = toInc;
                end
            end
            RELEASE: begin
                if (!endSync_p1 || toCnt == TO_LAST) begin
                    stateNxt = CHECK;
                end else begin
                    toNxt = toInc;
                end
            end
            CHECK: begin
                // A timed-out attempt is never retried, only NACKs are
                if (!ackReg && !errFlag) begin
                    doneNxt  = gntReg;
                    stateNxt = DONE;
                end else if (!errFlag && retryCnt < RETRY_MAX) begin
                    retryNxt = retryCnt + 3'd1;
                    stateNxt = ISSUE;
                end else begin
                    errFlagNxt = 1'b1;
                    doneNxt    = gntReg;
                    errNxt     = gntReg;
                    stateNxt   = DONE;
                end
            end
            DONE: begin
                gntNxt       = '0;
                lastGrantNxt = idxReg;
                stateNxt     = IDLE;
            end
            default: stateNxt = IDLE;
        endcase
    end

    assign oGNT  = gntReg;
    assign oDONE = doneReg;
    assign oERR  = errReg;
    assign oGO   = goReg;
    assign oDATA = dataReg;
    assign oBUSY = (state != IDLE);

endmodule

// File: tb/tb_i2c_cmd_arbiter.sv
// Bench for i2c_cmd_arbiter: engine model, done monitor and a round-robin
// transfer model that predicts grant order, attempt counts and error flags.
module tb_i2c_cmd_arbiter;
    import i2c_pkg::*;

    localparam int NR = 3;
    localparam int MR = 3;
    localparam int TO = 600;

    logic                iCLK = 1'b0;
    logic                iRST_N;
    logic [NR-1:0]       iREQ;
    logic [CMD_W*NR-1:0] iCMD;
    logic [NR-1:0]       oGNT, oDONE, oERR;
    logic                oGO, oBUSY;
    logic [CMD_W-1:0]    oDATA;
    logic                iEND, iACK;

    i2c_cmd_arbiter #(.NUM_REQ(NR), .MAX_RETRY(MR), .TIMEOUT_CYC(TO)) dut (
        .iCLK(iCLK), .iRST_N(iRST_N), .iREQ(iREQ), .iCMD(iCMD),
        .oGNT(oGNT), .oDONE(oDONE), .oERR(oERR), .oGO(oGO), .oDATA(oDATA),
        .iEND(iEND), .iACK(iACK), .oBUSY(oBUSY)
    );

    always #10 iCLK = ~iCLK;

    int          nTests = 0;
    int          nFail  = 0;
    int          reqAgain [NR];
    bit          engHang  = 1'b0;
    int          engDelay = 5;
    bit          ackPlan [$];
    int          attOwner [$];
    logic [23:0] attData [$];
    int          attLen [$];
    int          doneIdx [$];
    bit          doneErr [$];
    int          modelLast = NR - 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nTests++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int oneHotIdx(input logic [NR-1:0] v);
        for (int i = 0; i < NR; i++) if (v[i] === 1'b1) return i;
        return -1;
    endfunction

    function automatic logic [23:0] cmdOf(input int o);
        return iCMD[o*CMD_W +: CMD_W];
    endfunction

    // Engine: answers each GO after engDelay cycles unless hung, drops END later
    initial begin
        int  len;
        bit  fired;
        iEND = 1'b0;
        iACK = 1'b0;
        forever begin
            @(negedge iCLK);
            if (oGO === 1'b1) begin
                check("go_single_owner", 32'($onehot(oGNT)), 32'd1);
                attOwner.push_back(oneHotIdx(oGNT));
                attData.push_back(oDATA);
                len   = 0;
                fired = 1'b0;
                while (oGO === 1'b1) begin
                    len++;
                    if (!engHang && !fired && len == engDelay) begin
                        iACK  = (ackPlan.size() > 0) ? ackPlan.pop_front() : 1'b0;
                        iEND  = 1'b1;
                        fired = 1'b1;
                    end
                    @(negedge iCLK);
                end
                attLen.push_back(len);
                if (fired) begin
                    repeat (3) @(negedge iCLK);
                    iEND = 1'b0;
                    iACK = 1'b0;
                end
            end
        end
    end

    // Requesters: record completions, drop or keep the request level
    initial begin
        forever begin
            @(negedge iCLK);
            if (oDONE !== '0) begin
                int d;
                d = oneHotIdx(oDONE);
                check("done_onehot", 32'($onehot(oDONE)), 32'd1);
                check("done_gnt", 32'(oGNT), 32'(oDONE));
                check("err_lane", 32'(oERR & ~oDONE), 32'd0);
                doneIdx.push_back(d);
                if (d >= 0) begin
                    doneErr.push_back(oERR[d]);
                    if (reqAgain[d] > 0) reqAgain[d]--;
                    else iREQ[d] = 1'b0;
                end else begin
                    doneErr.push_back(1'b1);
                end
                @(negedge iCLK);
                check("idle_gap", {30'd0, oBUSY, |oGNT}, 32'd0);
            end
        end
    end

    task automatic doReset();
        @(negedge iCLK);
        iRST_N = 1'b0;
        iREQ   = '0;
        repeat (2) @(negedge iCLK);
        iRST_N    = 1'b1;
        modelLast = NR - 1;
    endtask

    task automatic runScenario(input string name, input logic [NR-1:0] reqs,
                               input int ag [NR], input bit lat);
        int            expIdx [$];
        bit            expErr [$];
        int            expAtt [$];
        bit            plan [$];
        logic [NR-1:0] pend;
        int            agn [NR];
        int            last, budget, w, n, cyc, j, total;
        bit            a;
        plan   = ackPlan;
        pend   = reqs;
        agn    = ag;
        last   = modelLast;
        budget = 100;
        total  = 0;
        while (pend != '0) begin
            w = -1;
            for (int k = 1; k <= NR; k++) begin
                int c;
                c = (last + k) % NR;
                if (w < 0 && pend[c]) w = c;
            end
            if (engHang) begin
                n = 1;
                a = 1'b1;
            end else begin
                n = 0;
                do begin
                    a = (plan.size() > 0) ? plan.pop_front() : 1'b0;
                    n++;
                end while (a && n <= MR);
            end
            expIdx.push_back(w);
            expErr.push_back(a);
            expAtt.push_back(n);
            total  += n;
            budget += n * ((engHang ? TO : engDelay) + 20);
            last = w;
            if (agn[w] > 0) agn[w]--;
            else pend[w] = 1'b0;
        end

        attOwner.delete(); attData.delete(); attLen.delete();
        doneIdx.delete(); doneErr.delete();
        reqAgain = ag;
        @(negedge iCLK);
        iREQ = reqs;
        if (lat) begin
            @(negedge iCLK);
            check({name, "/gnt_lat"}, 32'(oGNT), 32'(1 << expIdx[0]));
            check({name, "/go_before"}, 32'(oGO), 32'd0);
            @(negedge iCLK);
            check({name, "/go_lat"}, 32'(oGO), 32'd1);
            check({name, "/data"}, 32'(oDATA), 32'(cmdOf(expIdx[0])));
        end
        cyc = 0;
        while (doneIdx.size() < expIdx.size() && cyc < budget) begin
            @(negedge iCLK);
            cyc++;
        end
        check({name, "/transfers"}, 32'(doneIdx.size()), 32'(expIdx.size()));
        repeat (3) @(negedge iCLK);
        check({name, "/attempts"}, 32'(attOwner.size()), 32'(total));
        j = 0;
        for (int k = 0; k < expIdx.size() && k < doneIdx.size(); k++) begin
            check($sformatf("%s/idx%0d", name, k), 32'(doneIdx[k]), 32'(expIdx[k]));
            check($sformatf("%s/err%0d", name, k), 32'(doneErr[k]), 32'(expErr[k]));
            for (int r = 0; r < expAtt[k]; r++) begin
                if (j < attOwner.size()) begin
                    check($sformatf("%s/own%0d", name, j), 32'(attOwner[j]), 32'(expIdx[k]));
                    check($sformatf("%s/cmd%0d", name, j), 32'(attData[j]), 32'(cmdOf(expIdx[k])));
                    check($sformatf("%s/golen%0d", name, j), 32'(attLen[j]),
                          32'(engHang ? TO : engDelay + 2));
                end
                j++;
            end
        end
        check({name, "/idle"}, {29'd0, oBUSY, |oGNT, oGO}, 32'd0);
        modelLast = last;
        iREQ = '0;
    endtask

    initial begin
        int          cyc;
        int          ag [NR];
        logic [NR-1:0] rq;
        iRST_N = 1'b0;
        iREQ   = '0;
        iCMD   = '0;
        for (int i = 0; i < NR; i++) reqAgain[i] = 0;
        repeat (3) @(negedge iCLK);
        check("rst/gnt_done_err", {23'd0, oGNT, oDONE, oERR}, 32'd0);
        check("rst/go_busy", {30'd0, oGO, oBUSY}, 32'd0);
        check("rst/data", 32'(oDATA), 32'd0);
        iRST_N = 1'b1;

        iCMD[0 +: CMD_W] = {DEV_AUDIO, 8'h00, 8'h1A};
        engDelay = 500;
        ackPlan  = '{1'b0};
        runScenario("single", 3'b001, '{0, 0, 0}, 1'b1);

        doReset();
        for (int i = 0; i < NR; i++) iCMD[i*CMD_W +: CMD_W] = 24'($urandom);
        iCMD[CMD_W +: CMD_W] = {DEV_VIDEO, 8'h02, 8'h7F};
        engDelay = 8;
        ackPlan.delete();
        runScenario("contend", 3'b111, '{1, 0, 0}, 1'b0);

        ackPlan = '{1'b1, 1'b1, 1'b0};
        runScenario("nack_ack", 3'b010, '{0, 0, 0}, 1'b0);

        ackPlan = '{1'b1, 1'b1, 1'b1, 1'b1};
        runScenario("retry_exh", 3'b101, '{0, 0, 0}, 1'b0);

        engHang = 1'b1;
        runScenario("timeout", 3'b100, '{0, 0, 0}, 1'b0);

        // Reset while WAIT_END is holding GO
        for (int i = 0; i < NR; i++) iCMD[i*CMD_W +: CMD_W] = 24'($urandom);
        engDelay = 5;
        doneIdx.delete(); doneErr.delete();
        @(negedge iCLK);
        iREQ = 3'b001;
        cyc  = 0;
        while (oGO !== 1'b1 && cyc < 50) begin
            @(negedge iCLK);
            cyc++;
        end
        check("rstmid/go_seen", 32'(oGO), 32'd1);
        repeat (10) @(negedge iCLK);
        #3 iRST_N = 1'b0;
        #1;
        check("rstmid/gnt_done_err", {23'd0, oGNT, oDONE, oERR}, 32'd0);
        check("rstmid/go_busy", {30'd0, oGO, oBUSY}, 32'd0);
        check("rstmid/data", 32'(oDATA), 32'd0);
        iREQ = 3'b010;
        @(negedge iCLK);
        engHang = 1'b0;
        ackPlan.delete();
        iRST_N = 1'b1;
        @(negedge iCLK);
        check("rstmid/regrant", 32'(oGNT), 32'b010);
        cyc = 0;
        while (doneIdx.size() == 0 && cyc < 200) begin
            @(negedge iCLK);
            cyc++;
        end
        check("rstmid/done_cnt", 32'(doneIdx.size()), 32'd1);
        if (doneIdx.size() > 0) begin
            check("rstmid/done_idx", 32'(doneIdx[0]), 32'd1);
            check("rstmid/done_err", 32'(doneErr[0]), 32'd0);
        end
        repeat (3) @(negedge iCLK);
        iREQ      = '0;
        modelLast = 1;

        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < NR; i++) begin
                iCMD[i*CMD_W +: CMD_W] = 24'($urandom);
                ag[i] = int'($urandom_range(0, 1));
            end
            rq = NR'($urandom_range(1, (1 << NR) - 1));
            engDelay = int'($urandom_range(1, 20));
            ackPlan.delete();
            for (int p = 0; p < int'($urandom_range(0, 6)); p++)
                ackPlan.push_back(1'($urandom_range(0, 1)));
            runScenario($sformatf("rand%0d", t), rq, ag, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
